// File: rtl/nes_input_scheduler.sv
// Per-frame NES controller read sequencer: request, timed wait, publish held
// button state, and per-button press/release/auto-repeat pulses.
module nes_input_scheduler #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int REPEAT_DELAY   = 20,
  parameter int REPEAT_RATE    = 6
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_frame_strobe,
  output logic       o_read_req,
  input  logic       i_valid,
  input  logic [7:0] i_buttons,
  output logic [7:0] o_buttons,
  output logic [7:0] o_pressed,
  output logic [7:0] o_released,
  output logic [7:0] o_repeat,
  output logic       o_update,
  output logic       o_busy,
  output logic       o_fault,
  output logic       o_overrun,
  input  logic       i_clear_flags
);

  localparam int            CW      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TERM    = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    DELAY_V = 8'(REPEAT_DELAY);
  localparam logic [7:0]    RATE_V  = 8'(REPEAT_RATE);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_UPDATE
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_count;
  logic [7:0]    r_sample;
  logic [7:0]    r_buttons;
  logic [7:0]    r_pressed;
  logic [7:0]    r_released;
  logic [7:0]    r_repeat;
  logic          r_update;
  logic          r_read_req;
  logic          r_busy;
  logic          r_fault;
  logic          r_overrun;
  logic [7:0]    w_repeat;
  logic          w_terminal;
  logic          w_timeout;
  logic          w_set_overrun;

  assign w_terminal    = (r_count == TERM);
  assign w_timeout     = (r_state == ST_WAIT) && !i_valid && w_terminal;
  assign w_set_overrun = i_frame_strobe && (r_state != ST_IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (i_frame_strobe) w_state_next = ST_REQ;
      ST_REQ:    w_state_next = ST_WAIT;
      ST_WAIT:   if (i_valid || w_terminal) w_state_next = ST_UPDATE;
      ST_UPDATE: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Request and busy are registered copies of the next-state decode, so they
  // line up exactly with the state register without a combinational output.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_read_req <= 1'b0;
      r_busy     <= 1'b0;
      r_count    <= '0;
      r_sample   <= 8'h00;
    end else begin
      r_read_req <= (w_state_next == ST_REQ);
      r_busy     <= (w_state_next != ST_IDLE);
      if (r_state == ST_REQ) begin
        r_count <= '0;
      end else if ((r_state == ST_WAIT) && !i_valid && !w_terminal) begin
        r_count <= r_count + CW'(1);
      end
      if ((r_state == ST_WAIT) && i_valid) begin
        r_sample <= i_buttons;
      end else if (w_timeout) begin
        r_sample <= 8'h00;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_buttons  <= 8'h00;
      r_pressed  <= 8'h00;
      r_released <= 8'h00;
      r_repeat   <= 8'h00;
      r_update   <= 1'b0;
    end else if (r_state == ST_UPDATE) begin
      r_buttons  <= r_sample;
      r_pressed  <= r_sample & ~r_buttons;
      r_released <= ~r_sample & r_buttons;
      r_repeat   <= w_repeat;
      r_update   <= 1'b1;
    end else begin
      r_pressed  <= 8'h00;
      r_released <= 8'h00;
      r_repeat   <= 8'h00;
      r_update   <= 1'b0;
    end
  end

  // Set wins over a simultaneous clear so no event is ever lost.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fault   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_timeout) begin
        r_fault <= 1'b1;
      end else if (i_clear_flags) begin
        r_fault <= 1'b0;
      end
      if (w_set_overrun) begin
        r_overrun <= 1'b1;
      end else if (i_clear_flags) begin
        r_overrun <= 1'b0;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_repeat
      logic [7:0] r_timer;

      assign w_repeat[gi] = r_sample[gi] && r_buttons[gi] && (r_timer == 8'd1);

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_timer <= 8'h00;
        end else if (r_state == ST_UPDATE) begin
          if (r_sample[gi] && !r_buttons[gi]) begin
            r_timer <= DELAY_V;
          end else if (r_sample[gi]) begin
            if (r_timer == 8'd1) begin
              r_timer <= RATE_V;
            end else if (r_timer > 8'd1) begin
              r_timer <= r_timer - 8'd1;
            end
          end else begin
            r_timer <= 8'h00;
          end
        end
      end
    end
  endgenerate

  assign o_read_req = r_read_req;
  assign o_busy     = r_busy;
  assign o_buttons  = r_buttons;
  assign o_pressed  = r_pressed;
  assign o_released = r_released;
  assign o_repeat   = r_repeat;
  assign o_update   = r_update;
  assign o_fault    = r_fault;
  assign o_overrun  = r_overrun;

endmodule
